// File: rtl/nibble_serial_adder_if.sv
// Start/busy/done handshake and operand/result bundle for the nibble-serial adder.
interface nibble_serial_adder_if #(
   parameter int WIDTH = 16
);
   logic             start;
   logic             op;
   logic             cin;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             ovf;
   logic             zero;
   logic             neg;

   modport master (
      output start, op, cin, a, b,
      input  busy, done, result, cout, ovf, zero, neg
   );

   modport slave (
      input  start, op, cin, a, b,
      output busy, done, result, cout, ovf, zero, neg
   );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Multicycle WIDTH-bit add/sub built on one shared 4-bit ripple-carry adder, LSB nibble first.
// Optional macro NIBBLE_SERIAL_EARLY_DONE_EN ends RUN once the remaining upper nibbles are all zero.
module ripple_carry_adder4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [4:0] c;

   assign c[0] = ci;
   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end
   assign co = c[4];
endmodule

module nibble_serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input logic                  clk,
   input logic                  rst,
   nibble_serial_adder_if.slave bus
);
   localparam int NIBBLES = WIDTH / 4;
   localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

   if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_width_chk
      $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
   end

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_lat;
   logic [WIDTH-1:0] b_lat;   // already inverted for subtract
   logic [IW-1:0]    idx;
   logic             carry;
`ifdef NIBBLE_SERIAL_EARLY_DONE_EN
   logic             op_lat;
   logic             hi_nz;
`endif

   logic [3:0]       a_nib, b_nib, sum;
   logic             add_co;
   logic [WIDTH-1:0] res_next;
   logic             last;

   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (i == int'(idx)) begin
            a_nib = a_lat[4*i +: 4];
            b_nib = b_lat[4*i +: 4];
         end
      end
   end

   ripple_carry_adder4 u_rca (
      .a  (a_nib),
      .b  (b_nib),
      .ci (carry),
      .s  (sum),
      .co (add_co)
   );

   always_comb begin
      res_next = bus.result;
      for (int i = 0; i < NIBBLES; i++) begin
         if (i == int'(idx)) res_next[4*i +: 4] = sum;
      end
`ifdef NIBBLE_SERIAL_EARLY_DONE_EN
      hi_nz = 1'b0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (i > int'(idx)) hi_nz = hi_nz | (|(a_lat[4*i +: 4] | b_lat[4*i +: 4]));
      end
      // With no carry left and nothing above, every remaining nibble is zero.
      last = (idx == LAST) || (!op_lat && !hi_nz && !add_co);
      if (last) begin
         for (int i = 0; i < NIBBLES; i++) begin
            if (i > int'(idx)) res_next[4*i +: 4] = 4'h0;
         end
      end
`else
      last = (idx == LAST);
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         a_lat      <= '0;
         b_lat      <= '0;
         idx        <= '0;
         carry      <= 1'b0;
`ifdef NIBBLE_SERIAL_EARLY_DONE_EN
         op_lat     <= 1'b0;
`endif
         bus.busy   <= 1'b0;
         bus.done   <= 1'b0;
         bus.result <= '0;
         bus.cout   <= 1'b0;
         bus.ovf    <= 1'b0;
         bus.zero   <= 1'b0;
         bus.neg    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  a_lat    <= bus.a;
                  b_lat    <= bus.op ? ~bus.b : bus.b;
                  carry    <= bus.op ? 1'b1 : bus.cin;
`ifdef NIBBLE_SERIAL_EARLY_DONE_EN
                  op_lat   <= bus.op;
`endif
                  idx      <= '0;
                  bus.busy <= 1'b1;
                  state    <= RUN;
               end else begin
                  state    <= IDLE;
               end
            end
            RUN: begin
               bus.result <= res_next;
               carry      <= add_co;
               idx        <= idx + 1'b1;
               if (last) begin
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  bus.cout <= add_co;
                  bus.ovf  <= (a_lat[WIDTH-1] == b_lat[WIDTH-1]) &&
                              (res_next[WIDTH-1] != a_lat[WIDTH-1]);
                  bus.zero <= (res_next == '0);
                  bus.neg  <= res_next[WIDTH-1];
                  state    <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl: latency, add/sub flags, back-to-back, reset abort.
module tb_nibble_serial_adder_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   pass_cnt = 0;
   int   fail_cnt = 0;
   int   total_cnt = 0;

   always #5 clk = ~clk;

   nibble_serial_adder_if #(.WIDTH(16)) bus ();

   nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

`ifdef NIBBLE_SERIAL_EARLY_DONE_EN
   localparam int SMALL_LAT = 2;
`else
   localparam int SMALL_LAT = 5;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Accept one operation, scramble operands and pulse start mid-RUN, then check result.
   task automatic run_op(input string tag, input logic op, input logic cin,
                         input logic [15:0] a, input logic [15:0] b, input int lat,
                         input logic [15:0] res, input logic co, input logic ov,
                         input logic zr, input logic ng);
      int   n;
      logic got;
      @(negedge clk);
      bus.start = 1'b1; bus.op = op; bus.cin = cin; bus.a = a; bus.b = b;
      @(posedge clk);
      #1;
      bus.start = 1'b0; bus.a = 16'hDEAD; bus.b = 16'hBEEF; bus.op = ~op; bus.cin = ~cin;
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (n == 1) chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
         if (bus.done) got = 1'b1;
         else bus.start = (n == 2);
      end
      bus.start = 1'b0;
      chk({tag, "_lat"},  32'(n), 32'(lat));
      chk({tag, "_res"},  32'(bus.result), 32'(res));
      chk({tag, "_cout"}, 32'(bus.cout), 32'(co));
      chk({tag, "_ovf"},  32'(bus.ovf), 32'(ov));
      chk({tag, "_zero"}, 32'(bus.zero), 32'(zr));
      chk({tag, "_neg"},  32'(bus.neg), 32'(ng));
      @(negedge clk);
      chk({tag, "_idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
      chk({tag, "_hold"}, 32'(bus.result), 32'(res));
   endtask

   initial begin
      int   n;
      logic got;
      logic seen;
      bus.start = 1'b0; bus.op = 1'b0; bus.cin = 1'b0; bus.a = '0; bus.b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ctl",   {30'd0, bus.busy, bus.done}, 32'd0);
      chk("rst_res",   32'(bus.result), 32'd0);
      chk("rst_flags", {28'd0, bus.cout, bus.ovf, bus.zero, bus.neg}, 32'd0);
      rst = 1'b0;

      run_op("add1",   1'b0, 1'b0, 16'h1234, 16'h0FFF, 5, 16'h2233, 1'b0, 1'b0, 1'b0, 1'b0);
      run_op("wrap",   1'b0, 1'b0, 16'hFFFF, 16'h0001, 5, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
      run_op("wrapc",  1'b0, 1'b1, 16'hFFFF, 16'h0001, 5, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0);
      run_op("subovf", 1'b1, 1'b1, 16'h8000, 16'h0001, 5, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
      run_op("addovf", 1'b0, 1'b0, 16'h7FFF, 16'h0001, 5, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
      run_op("subneg", 1'b1, 1'b0, 16'h0003, 16'h0005, 5, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);

      // Back-to-back with start held high through RUN and DONE.
      @(negedge clk);
      bus.start = 1'b1; bus.op = 1'b0; bus.cin = 1'b0; bus.a = 16'h00FF; bus.b = 16'h0F01;
      @(posedge clk);
      #1;
      bus.a = 16'h4000; bus.b = 16'h4000;
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         got = bus.done;
      end
      chk("b2b_lat1", 32'(n), 32'd5);
      chk("b2b_res1", 32'(bus.result), 32'h1000);
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         bus.start = 1'b0;
         got = bus.done;
      end
      chk("b2b_lat2", 32'(n), 32'd5);
      chk("b2b_res2", 32'(bus.result), 32'h8000);
      chk("b2b_flg2", {28'd0, bus.cout, bus.ovf, bus.zero, bus.neg}, 32'b0101);

      // Reset during the second RUN cycle aborts the operation.
      @(negedge clk);
      bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h2222; bus.op = 1'b0; bus.cin = 1'b0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_ctl", {30'd0, bus.busy, bus.done}, 32'd0);
      chk("abort_res", 32'(bus.result), 32'd0);
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         seen = seen | bus.done | bus.busy;
      end
      chk("abort_nodone", 32'(seen), 32'd0);

      run_op("small",  1'b0, 1'b0, 16'h0003, 16'h0004, SMALL_LAT, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
